// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load/clear, terminal count, wrap pulse and sticky overflow.
// Define COUNTER_SAT_EN to compile in saturate mode; otherwise sat_mode is ignored and the counter always wraps.
module mod_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dir,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             overflow_q, overflow_d;

    logic             at_max;
    logic             at_zero;
    logic             boundary;
    logic             sat_active;
    logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_SAT_EN
    assign sat_active = sat_mode;
`else
    logic sat_mode_unused;
    assign sat_mode_unused = sat_mode;
    assign sat_active      = 1'b0;
`endif

    assign at_max       = (count_q == MAX_C);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (load_value > MAX_C) ? MAX_C : load_value;

    // Terminal count looks at the boundary in the current direction, regardless of enable.
    assign tc       = dir ? at_max : at_zero;
    assign boundary = enable & tc;

    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        overflow_d   = overflow_q;

        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            if (boundary) begin
                wrap_pulse_d = 1'b1;
                overflow_d   = 1'b1;
                if (!sat_active) begin
                    count_d = dir ? '0 : MAX_C;
                end
            end else if (dir) begin
                count_d = count_q + ONE_C;
            end else begin
                count_d = count_q - ONE_C;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            wrap_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
            overflow_q   <= overflow_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign overflow   = overflow_q;

endmodule
